// File: rtl/req_ack_pkg.sv
// Shared types for the req/ack receive controller.
// Holds the FSM state encoding and counter widths.
package req_ack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    VALID,
    ACK,
    ERR
  } state_t;

  localparam int XFER_CNT_W = 16;
  localparam int TMO_W      = 16;

  function automatic logic [TMO_W-1:0] tmo_last(input int timeout);
    return TMO_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/req_ack_rx_level_filter.sv
// Level filter for a synchronized request line.
// Output follows the input only after FILTER_CYCLES equal samples.
module level_filter #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int CW = (FILTER_CYCLES > 2) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count consecutive samples that differ from the output; flip on the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (in == out) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      out <= in;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/req_ack_rx.sv
// Receive-side 4-phase req/ack controller with timeout.
// Optional req glitch filter enabled by macro REQ_FILTER_EN.
module req_ack_rx
  import req_ack_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int TIMEOUT       = 255,
  parameter int FILTER_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_sync,
  input  logic [DATA_W-1:0]     xdata,
  input  logic                  rx_ready,
  output logic                  rx_valid,
  output logic [DATA_W-1:0]     rx_data,
  output logic                  ack,
  output logic                  timeout_err,
  output logic [XFER_CNT_W-1:0] xfer_count
);

  localparam logic [TMO_W-1:0] TMO_LAST = tmo_last(TIMEOUT);

  state_t           state;
  state_t           state_nxt;
  logic             req_q;
  logic [TMO_W-1:0] tmo;

  logic capture_en;
  logic xfer_inc;
  logic tmo_clr;
  logic tmo_inc;
  logic err_set;

`ifdef REQ_FILTER_EN
  level_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk (clk),
    .rst (rst),
    .in  (req_sync),
    .out (req_q)
  );
`else
  localparam int filter_unused = FILTER_CYCLES;
  assign req_q = req_sync;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_nxt  = state;
    capture_en = 1'b0;
    xfer_inc   = 1'b0;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_q) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        capture_en = 1'b1;
        state_nxt  = VALID;
      end
      VALID: begin
        if (rx_ready) begin
          xfer_inc  = 1'b1;
          tmo_clr   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!req_q) begin
          state_nxt = IDLE;
        end else if (tmo == TMO_LAST) begin
          err_set   = 1'b1;
          state_nxt = ERR;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      ERR: begin
        if (!req_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured word; holds until the next CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rx_data <= '0;
    else if (capture_en) rx_data <= xdata;
  end

  // Accepted-transfer counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           xfer_count <= '0;
    else if (xfer_inc) xfer_count <= xfer_count + XFER_CNT_W'(1);
  end

  // Cycles spent in ACK waiting for req to fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tmo <= '0;
    else if (tmo_clr) tmo <= '0;
    else if (tmo_inc) tmo <= tmo + TMO_W'(1);
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          timeout_err <= 1'b0;
    else if (err_set) timeout_err <= 1'b1;
  end

  assign rx_valid = (state == VALID);
  assign ack      = (state == ACK);

endmodule

// File: tb/tb_req_ack_rx.sv
// Directed bench for req_ack_rx (TIMEOUT=16).
// Honors REQ_FILTER_EN for the glitch scenario.
module tb_req_ack_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_sync;
  logic [7:0]  xdata;
  logic        rx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        ack;
  logic        timeout_err;
  logic [15:0] xfer_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  req_ack_rx #(
    .DATA_W        (8),
    .TIMEOUT       (16),
    .FILTER_CYCLES (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_sync    (req_sync),
    .xdata       (xdata),
    .rx_ready    (rx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .ack         (ack),
    .timeout_err (timeout_err),
    .xfer_count  (xfer_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int n;
  int nv;
  int na;
  logic vseen;

  initial begin
    rst      = 1'b1;
    req_sync = 1'b1;
    xdata    = 8'hFF;
    rx_ready = 1'b1;

    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst_valid", rx_valid, 0);
      chk("rst_ack", ack, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_cnt", xfer_count, 0);
      chk("rst_terr", timeout_err, 0);
    end

`ifdef REQ_FILTER_EN
    req_sync = 1'b0;
    rst = 1'b0;
    tick;
    tick;
`else
    rst = 1'b0;
    tick;
    chk("post_rst_cap", rx_valid, 0);
    tick;
    chk("post_rst_valid", rx_valid, 1);
    chk("post_rst_data", rx_data, 8'hFF);
    req_sync = 1'b0;
    tick;
    chk("post_rst_ack", ack, 1);
    chk("post_rst_cnt", xfer_count, 1);
    tick;
    chk("post_rst_ack_fall", ack, 0);

    xdata    = 8'hA5;
    req_sync = 1'b1;
    tick;
    chk("basic_cap", rx_valid, 0);
    tick;
    chk("basic_valid", rx_valid, 1);
    chk("basic_data", rx_data, 8'hA5);
    chk("basic_no_ack", ack, 0);
    tick;
    chk("basic_valid_1cyc", rx_valid, 0);
    chk("basic_ack", ack, 1);
    chk("basic_cnt", xfer_count, 2);
    tick;
    chk("basic_ack_hold", ack, 1);
    req_sync = 1'b0;
    tick;
    chk("basic_ack_fall", ack, 0);
    chk("basic_cnt2", xfer_count, 2);

    rx_ready = 1'b0;
    xdata    = 8'h3C;
    req_sync = 1'b1;
    tick;
    tick;
    chk("bp_valid", rx_valid, 1);
    chk("bp_data", rx_data, 8'h3C);
    xdata = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold_valid", rx_valid, 1);
      chk("bp_hold_data", rx_data, 8'h3C);
      chk("bp_hold_ack", ack, 0);
    end
    rx_ready = 1'b1;
    tick;
    chk("bp_ack", ack, 1);
    chk("bp_valid_drop", rx_valid, 0);
    chk("bp_cnt", xfer_count, 3);
    req_sync = 1'b0;
    tick;
    chk("bp_ack_fall", ack, 0);

    xdata    = 8'h5A;
    req_sync = 1'b1;
    tick;
    tick;
    chk("tmo_valid", rx_valid, 1);
    chk("tmo_data", rx_data, 8'h5A);
    tick;
    chk("tmo_ack", ack, 1);
    chk("tmo_cnt", xfer_count, 4);
    n = 1;
    vseen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      vseen |= rx_valid;
      if (!ack) break;
      n++;
    end
    chk("tmo_ack_cycles", n, 16);
    chk("tmo_err", timeout_err, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      vseen |= rx_valid;
      chk("tmo_err_ack", ack, 0);
    end
    chk("tmo_no_revalid", vseen, 0);
    req_sync = 1'b0;
    tick;
    xdata    = 8'hC3;
    req_sync = 1'b1;
    tick;
    tick;
    chk("tmo_re_valid", rx_valid, 1);
    chk("tmo_re_data", rx_data, 8'hC3);
    tick;
    chk("tmo_re_ack", ack, 1);
    chk("tmo_re_cnt", xfer_count, 5);
    req_sync = 1'b0;
    tick;
    chk("tmo_re_ack_fall", ack, 0);
    chk("tmo_err_sticky", timeout_err, 1);

    xdata    = 8'h11;
    req_sync = 1'b1;
    tick;
    tick;
    tick;
    chk("mid_ack_pre", ack, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_cnt", xfer_count, 0);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_terr", timeout_err, 0);
    req_sync = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("mid_rst_idle_ack", ack, 0);
    chk("mid_rst_idle_valid", rx_valid, 0);
`endif

    xdata    = 8'h77;
    rx_ready = 1'b1;
    req_sync = 1'b1;
    nv = 0;
    na = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (i == 1) req_sync = 1'b0;
      nv += int'(rx_valid);
      na += int'(ack);
    end
`ifdef REQ_FILTER_EN
    chk("glitch_valid", nv, 0);
    chk("glitch_ack", na, 0);
    chk("glitch_cnt", xfer_count, 0);
    chk("glitch_data", rx_data, 0);
`else
    chk("glitch_valid", nv, 1);
    chk("glitch_ack", na, 1);
    chk("glitch_cnt", xfer_count, 1);
    chk("glitch_data", rx_data, 8'h77);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
